mem_line_responder: RTL

Main-memory responder at the far end of the cache line-fill interface. Serves line requests from the instruction-fetch side and the data-memory side, one at a time, after a fixed access latency, with round-robin arbitration between the two. Data-side requests may be line writebacks. Sits between the I/Dmem miss logic and the backing storage; the stall signals those stages raise last exactly until this block acknowledges.

---
 rtl/mem_line_responder_if.sv | 32 +++
 rtl/mem_line_responder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mem_line_responder_if.sv
// Line-fill bus between the I/D miss logic and the memory responder.
// Two request channels; the data channel also carries writebacks.
interface mem_line_responder_if #(
    parameter int ADDRESS_SIZE = 32,
    parameter int LINE_SIZE    = 128
);
    logic                    ifill_req;
    logic [ADDRESS_SIZE-1:0] ifill_addr;
    logic                    ifill_ack;
    logic [LINE_SIZE-1:0]    ifill_data;

    logic                    dfill_req;
    logic [ADDRESS_SIZE-1:0] dfill_addr;
    logic                    dfill_we;
    logic [LINE_SIZE-1:0]    dfill_wdata;
    logic                    dfill_ack;
    logic [LINE_SIZE-1:0]    dfill_data;

    modport master (
        output ifill_req, ifill_addr,
        input  ifill_ack, ifill_data,
        output dfill_req, dfill_addr, dfill_we, dfill_wdata,
        input  dfill_ack, dfill_data
    );

    modport slave (
        input  ifill_req, ifill_addr,
        output ifill_ack, ifill_data,
        input  dfill_req, dfill_addr, dfill_we, dfill_wdata,
        output dfill_ack, dfill_data
    );
endinterface

// File: rtl/mem_line_responder.sv
// Fixed-latency line memory serving I/D fills, round-robin arbitrated.
// MEM_LINE_RESPONDER_STATS_EN adds ack and busy-cycle counters.
module mem_line_responder #(
    parameter int ADDRESS_SIZE = 32,
    parameter int LINE_SIZE    = 128,
    parameter int MEM_SIZE     = 32'h1000,
    parameter int LATENCY      = 5
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MEM_LINE_RESPONDER_STATS_EN
    output logic [31:0] stat_ifills,
    output logic [31:0] stat_dfills,
    output logic [31:0] stat_busy_cycles,
`endif
    mem_line_responder_if.slave bus
);
    localparam int LINE_BYTES = LINE_SIZE / 8;
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int LINES      = MEM_SIZE / LINE_BYTES;
    localparam int IDX_W      = $clog2(LINES);
    localparam int CNT_W      = $clog2(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 gnt_d_q;
    logic                 last_d_q;
    logic                 we_q;
    logic [IDX_W-1:0]     idx_q;
    logic [LINE_SIZE-1:0] wdata_q;
    logic                 ifill_ack_q;
    logic                 dfill_ack_q;
    logic [LINE_SIZE-1:0] ifill_data_q;
    logic [LINE_SIZE-1:0] dfill_data_q;

    logic [LINE_SIZE-1:0] mem [LINES];

    logic                 any_req;
    logic                 grant_d;
    logic                 fire;
    logic [LINE_SIZE-1:0] resp;
    logic                 unused_addr;

    assign any_req = bus.ifill_req | bus.dfill_req;
    assign fire    = (state_q == BUSY) && (cnt_q == '0);
    assign resp    = we_q ? wdata_q : mem[idx_q];

    assign unused_addr = ^{bus.ifill_addr, bus.dfill_addr};

    assign bus.ifill_ack  = ifill_ack_q;
    assign bus.dfill_ack  = dfill_ack_q;
    assign bus.ifill_data = ifill_data_q;
    assign bus.dfill_data = dfill_data_q;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        grant_d = 1'b0;
        unique case (1'b1)
            bus.ifill_req && bus.dfill_req:  grant_d = !last_d_q;
            bus.dfill_req && !bus.ifill_req: grant_d = 1'b1;
            default:                         grant_d = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = BUSY;
            BUSY:    if (cnt_q == '0) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            gnt_d_q      <= 1'b0;
            last_d_q     <= 1'b1;
            we_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            ifill_ack_q  <= 1'b0;
            dfill_ack_q  <= 1'b0;
            ifill_data_q <= '0;
            dfill_data_q <= '0;
        end else begin
            state_q     <= state_d;
            ifill_ack_q <= fire && !gnt_d_q;
            dfill_ack_q <= fire && gnt_d_q;
            if (state_q == IDLE && any_req) begin
                gnt_d_q <= grant_d;
                cnt_q   <= CNT_W'(LATENCY - 2);
                we_q    <= grant_d && bus.dfill_we;
                wdata_q <= bus.dfill_wdata;
                idx_q   <= grant_d ? bus.dfill_addr[OFF_W +: IDX_W]
                                   : bus.ifill_addr[OFF_W +: IDX_W];
            end
            if (state_q == BUSY && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (fire) begin
                if (gnt_d_q) dfill_data_q <= resp;
                else         ifill_data_q <= resp;
            end
            if (state_q == ACK) begin
                last_d_q <= gnt_d_q;
            end
        end
    end

    // Storage survives reset; a reset during BUSY suppresses the write.
    always_ff @(posedge clk) begin
        if (reset && fire && we_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

`ifdef MEM_LINE_RESPONDER_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_ifills      <= '0;
            stat_dfills      <= '0;
            stat_busy_cycles <= '0;
        end else begin
            if (ifill_ack_q) stat_ifills <= stat_ifills + 32'd1;
            if (dfill_ack_q) stat_dfills <= stat_dfills + 32'd1;
            if (state_q != IDLE) begin
                stat_busy_cycles <= stat_busy_cycles + 32'd1;
            end
        end
    end
`endif
endmodule
